xor_stream_descrambler: RTL and testbench
=========================================

Name: xor_stream_descrambler

Overview:
Receive-side counterpart of the chip's XOR data path: recovers plaintext bytes from a keystream-scrambled byte stream. Hunts for a sync byte, loads a per-frame LFSR seed from the following byte, then XORs each of FRAME_LEN payload bytes with the running keystream. Sits between the input pins (ui_in/uio_in) and the uo_out driver in the top-level wrapper, with valid/ready handshakes on both sides.

Parameters:
SYNC_BYTE, 8'hA5, frame delimiter searched for in HUNT.
FRAME_LEN, 16, payload bytes per frame; legal range 1..255.
LFSR_TAPS, 8'h1D, Galois feedback mask (x^8+x^4+x^3+x^2+1).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  8  scrambled byte
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted when in_valid && in_ready
out_data  out  8  descrambled byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when out_valid && out_ready
locked  out  1  high while in DATA state
frame_done  out  1  one-cycle pulse on acceptance of last payload byte
frame_err  out  1  one-cycle pulse on illegal (zero) seed

Behaviour:
- Reset (async assert, sync-safe release): state=HUNT, lfsr=8'h01, count=0, out_data=0, out_valid=0, frame_done=0, frame_err=0, locked=0.
- "Accept" = in_valid && in_ready at a rising edge.
- in_ready: 1 in HUNT and SEED; in DATA = !out_valid || out_ready (combinational from registered out_valid and the out_ready input).
- HUNT: accepted byte == SYNC_BYTE -> SEED; otherwise discard, stay. No output produced.
- SEED: accepted byte != 0 -> lfsr<=byte, count<=0, -> DATA. Byte == 0 -> frame_err pulse, -> HUNT. A byte equal to SYNC_BYTE is a legal seed.
- DATA: on accept: out_data<=in_data^lfsr, out_valid<=1, lfsr<=(lfsr<<1)^(lfsr[7]?LFSR_TAPS:8'h00), count<=count+1. When count==FRAME_LEN-1 at accept: frame_done pulse same cycle as out_data load, -> HUNT.
- Key for payload byte k (0-based) is the LFSR value after k steps from seed; first byte uses seed unmodified.
- Latency: accept at edge N -> out_valid high after edge N, one cycle.
- Output register: out_valid cleared on edge where out_valid && out_ready and no new accept; simultaneous drain+accept keeps out_valid=1 with new data (full throughput, 1 byte/cycle).
- Backpressure: out_valid && !out_ready holds out_data, in_ready=0, lfsr/count frozen.
- Last payload byte may still be pending on output after return to HUNT; HUNT/SEED acceptance does not touch output register.
- count is 8 bits; no wrap possible given FRAME_LEN<=255.
- rst mid-frame: immediate abort, all state to reset values, pending output discarded.
- locked = (state==DATA), registered-state-derived, no glitch path from inputs.

Decomposition:
- Shared package xor_stream_pkg: state enum {HUNT, SEED, DATA}, SYNC_BYTE and LFSR_TAPS defaults, lfsr_next function (also used by the matching scrambler so both ends share one keystream definition).
- One natural sub-module: xor_keystream_lfsr (load, step, 8-bit state output), reused unchanged by the transmit-side scrambler.

Test Plan:
- Reset then bytes 00,A5,01,41,42,44 with out_ready=1 -> no output for 00/A5/01; outputs 40,40,40 (keys 01,02,04); locked rises after seed accept.
- FRAME_LEN=4, seed 80, payload 00,00,00,00 -> outputs 80,1D,3A,74; frame_done pulses with 4th byte; locked falls next cycle.
- Sync then seed 00 -> frame_err single-cycle pulse, state HUNT, no output; following A5,01,FF -> output FE.
- Backpressure: out_ready=0 for 3 cycles mid-frame with in_valid=1 -> out_data held, in_ready=0, no keystream advance; resume yields continuous correct sequence, no lost/duplicated bytes.
- Assert rst during payload byte 5 -> all outputs 0 immediately; post-reset A5,01,41 -> output 40 (fresh keystream).
- Random payload through matching scrambler, 1000 frames, random in_valid/out_ready -> descrambled output equals original, frame_done count equals frame count.

Source files
------------

// File: rtl/xor_stream_pkg.sv
// Shared definitions for the XOR stream scrambler/descrambler pair: FSM states, defaults, keystream step.
// Combinational helpers only, no latency.
// No flow control lives here.
package xor_stream_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SEED = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'h1D;
    localparam logic [7:0] LFSR_RESET        = 8'h01;

    // One Galois step; both ends of the link must agree on this exact definition.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur, input logic [7:0] taps);
        return {cur[6:0], 1'b0} ^ (cur[7] ? taps : 8'h00);
    endfunction

endpackage

// File: rtl/xor_keystream_lfsr.sv
// 8-bit Galois keystream register: parallel seed load or single step per cycle.
// New key visible one cycle after load/step.
// Holds its value whenever neither load nor step is asserted.
module xor_keystream_lfsr
    import xor_stream_pkg::*;
#(
    parameter logic [7:0] TAPS = LFSR_TAPS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] key
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key <= LFSR_RESET;
        end else if (load) begin
            key <= seed;
        end else if (step) begin
            key <= lfsr_next(key, TAPS);
        end
    end

endmodule

// File: rtl/xor_stream_descrambler.sv
// Sync-hunting descrambler: finds SYNC_BYTE, loads the seed, XORs FRAME_LEN payload bytes with the keystream.
// One cycle from input accept to out_valid; full throughput of one byte per cycle.
// Stalled output register drops in_ready during DATA and freezes keystream and byte count.
module xor_stream_descrambler
    import xor_stream_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         FRAME_LEN = 16,
    parameter logic [7:0] LFSR_TAPS = LFSR_TAPS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       locked,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t     state;
    logic [7:0] count;
    logic [7:0] key;
    logic       accept;
    logic       seed_ok;
    logic       lfsr_load;
    logic       lfsr_step;

    // HUNT/SEED never produce output, so only DATA is subject to output backpressure.
    assign in_ready  = (state != DATA) || !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign seed_ok   = (in_data != 8'h00);
    assign lfsr_load = accept && (state == SEED) && seed_ok;
    assign lfsr_step = accept && (state == DATA);
    assign locked    = (state == DATA);

    xor_keystream_lfsr #(
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (in_data),
        .step (lfsr_step),
        .key  (key)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            count      <= 8'd0;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                HUNT: begin
                    if (accept && (in_data == SYNC_BYTE)) begin
                        state <= SEED;
                    end
                end
                SEED: begin
                    if (accept) begin
                        if (seed_ok) begin
                            count <= 8'd0;
                            state <= DATA;
                        end else begin
                            // An all-zero seed would lock the keystream at zero forever.
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        out_data  <= in_data ^ key;
                        out_valid <= 1'b1;
                        count     <= count + 8'd1;
                        if (count == LAST_IDX) begin
                            frame_done <= 1'b1;
                            state      <= HUNT;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Scoreboard bench: directed frames plus 1000 random frames scrambled by a bench-side keystream model.
module tb_xor_stream_descrambler;

    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       locked;
    logic       frame_done;
    logic       frame_err;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   frames_exp = 0;
    bit   rand_rdy = 1'b0;
    logic rdy_val = 1'b1;

    xor_stream_descrambler #(
        .SYNC_BYTE (8'hA5),
        .FRAME_LEN (FL),
        .LFSR_TAPS (8'h1D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .locked     (locked),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : rdy_val;
    end

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] key_next(input logic [7:0] k);
        int v;
        v = int'(k) * 2;
        if (v >= 256) v = (v - 256) ^ 'h1D;
        return 8'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic last);
        exp_t e;
        e.d    = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        int   t;
        in_data  = b;
        in_valid = 1'b1;
        acc      = 1'b0;
        t        = 0;
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte %02h not accepted in %0d cycles", b, t);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) begin
                done_cnt++;
                n_tests++;
                if (!out_valid || exp_q.size() == 0 || !exp_q[0].last) begin
                    n_fail++;
                    $display("FAIL frame_done_align: out_valid=%0b pending=%0d", out_valid, exp_q.size());
                end
            end
            if (frame_err) err_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %02h expected none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", out_data, mon_e.d);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] key;
        logic [7:0] p;
        int         ng;

        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_locked", locked, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic frame: noise, sync, seed 01, keys 01,02,04,08.
        send(8'h00);
        send(8'hA5);
        check("locked_before_seed", locked, 0);
        send(8'h01);
        check("locked_after_seed", locked, 1);
        push_exp(8'h40, 1'b0);
        push_exp(8'h40, 1'b0);
        push_exp(8'h40, 1'b0);
        push_exp(8'h40, 1'b1);
        send(8'h41);
        send(8'h42);
        send(8'h44);
        send(8'h48);
        frames_exp++;
        drain();

        // Seed 80 exercises feedback taps; zero payload exposes raw keystream.
        send(8'hA5);
        send(8'h80);
        push_exp(8'h80, 1'b0);
        push_exp(8'h1D, 1'b0);
        push_exp(8'h3A, 1'b0);
        push_exp(8'h74, 1'b1);
        repeat (4) send(8'h00);
        check("frame_done_pulse", frame_done, 1);
        check("locked_after_frame", locked, 0);
        idle(1);
        check("frame_done_clear", frame_done, 0);
        frames_exp++;
        drain();

        // Zero seed error, then recovery.
        send(8'hA5);
        send(8'h00);
        check("frame_err_pulse", frame_err, 1);
        check("locked_after_err", locked, 0);
        idle(1);
        check("frame_err_clear", frame_err, 0);
        send(8'hA5);
        send(8'h01);
        push_exp(8'hFE, 1'b0);
        push_exp(8'h02, 1'b0);
        push_exp(8'h04, 1'b0);
        push_exp(8'h08, 1'b1);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        frames_exp++;
        drain();

        // Output stall mid-frame.
        rdy_val = 1'b0;
        idle(2);
        send(8'hA5);
        send(8'h01);
        push_exp(8'h11, 1'b0);
        push_exp(8'h22, 1'b0);
        push_exp(8'h34, 1'b0);
        push_exp(8'h48, 1'b1);
        send(8'h10);
        in_data  = 8'h20;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, 8'h11);
        end
        rdy_val = 1'b1;
        send(8'h20);
        send(8'h30);
        send(8'h40);
        frames_exp++;
        drain();

        // Reset mid-frame discards pending output and restarts the keystream.
        send(8'hA5);
        send(8'h01);
        push_exp(8'h40, 1'b0);
        send(8'h41);
        send(8'h42);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_locked", locked, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_pending", exp_q.size(), 0);
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        send(8'hA5);
        send(8'h01);
        push_exp(8'h40, 1'b0);
        push_exp(8'h40, 1'b0);
        push_exp(8'h40, 1'b0);
        push_exp(8'h40, 1'b1);
        send(8'h41);
        send(8'h42);
        send(8'h44);
        send(8'h48);
        frames_exp++;
        drain();

        // Random frames with random gaps and random output backpressure.
        rand_rdy = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            ng = $urandom_range(0, 2);
            repeat (ng) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send(b);
            end
            send(8'hA5);
            key = 8'($urandom_range(1, 255));
            send(key);
            for (int k = 0; k < FL; k++) begin
                p = 8'($urandom);
                push_exp(p, k == FL - 1);
                send(p ^ key);
                key = key_next(key);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            frames_exp++;
        end
        rand_rdy = 1'b0;
        drain();
        idle(2);
        check("frame_done_count", done_cnt, frames_exp);
        check("frame_err_count", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
